// File: rtl/eth_tx_arb_pkg.sv
// Shared types and counter widths for the eth_tx packet arbiter.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    DATA,
    GAP
  } arb_state_t;

  // Counter widths cover TMO_CYC up to 65535, GAP_CYC up to 255 and REQ_N up to 256.
  localparam int unsigned TMO_W = 16;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned PTR_W = 8;

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned REQ_N = 2
) (
  input  logic [REQ_N-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [REQ_N-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic found;

  // Two passes: indices >= ptr first, then the wrapped lower indices.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level round-robin arbiter sharing one eth_tx pipe between REQ_N streams.
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned REQ_N     = 2,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned KEEP_W    = DATA_W / 8,
  parameter int unsigned LEN_W     = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W = 16,
  parameter int unsigned UDP_CS_W  = 16,
  parameter int unsigned GAP_CYC   = 3,
  parameter int unsigned TMO_CYC   = 64
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [REQ_N-1:0]           req_early_v_i,
  input  logic [REQ_N*PKT_LEN_W-1:0] req_pkt_len_i,
  input  logic [REQ_N*UDP_CS_W-1:0]  req_cs_i,
  input  logic [REQ_N-1:0]           req_cancel_i,
  input  logic [REQ_N-1:0]           req_valid_i,
  input  logic [REQ_N*DATA_W-1:0]    req_data_i,
  input  logic [REQ_N*LEN_W-1:0]     req_len_i,
  output logic [REQ_N-1:0]           req_gnt_o,
  output logic [REQ_N-1:0]           req_ready_o,
  output logic                       app_early_v_o,
  output logic [PKT_LEN_W-1:0]       app_pkt_len_o,
  output logic [UDP_CS_W-1:0]        app_cs_o,
  output logic                       app_cancel_o,
  output logic                       app_valid_o,
  output logic [DATA_W-1:0]          app_data_o,
  output logic [LEN_W-1:0]           app_len_o,
  input  logic                       app_ready_v_i,
  output logic                       err_o
);

  arb_state_t           state_q, state_d;
  logic [REQ_N-1:0]     gnt_q, gnt_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PKT_LEN_W-1:0] plen_q, plen_d;
  logic [UDP_CS_W-1:0]  cs_q, cs_d;
  logic [PKT_LEN_W-1:0] rem_q, rem_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 cancel_q, cancel_d;
  logic                 err_q, err_d;
  logic                 end_pkt;

  logic [REQ_N-1:0]     pick_gnt;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [PKT_LEN_W-1:0] pick_len;
  logic [UDP_CS_W-1:0]  pick_cs;

  logic [DATA_W-1:0]    g_data;
  logic [LEN_W-1:0]     g_len;
  logic                 g_valid;
  logic                 g_cancel;
  logic [PKT_LEN_W-1:0] blen;
  logic                 data_ok;
  logic                 beat_acc;

  rr_pick #(
    .REQ_N (REQ_N)
  ) u_pick (
    .req (req_early_v_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // AND-OR muxes keyed on one-hot grants; an empty grant yields all zeros.
  always_comb begin
    pick_len = '0;
    pick_cs  = '0;
    g_data   = '0;
    g_len    = '0;
    g_valid  = 1'b0;
    g_cancel = 1'b0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (pick_gnt[i]) begin
        pick_len = pick_len | req_pkt_len_i[i*PKT_LEN_W +: PKT_LEN_W];
        pick_cs  = pick_cs  | req_cs_i[i*UDP_CS_W +: UDP_CS_W];
      end
      if (gnt_q[i]) begin
        g_data   = g_data | req_data_i[i*DATA_W +: DATA_W];
        g_len    = g_len  | req_len_i[i*LEN_W +: LEN_W];
        g_valid  = g_valid  | req_valid_i[i];
        g_cancel = g_cancel | req_cancel_i[i];
      end
    end
  end

  assign blen     = PKT_LEN_W'(g_len);
  assign data_ok  = (state_q == DATA) && app_ready_v_i && !g_cancel && (rem_q != '0);
  assign beat_acc = data_ok && g_valid;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    plen_d   = plen_q;
    cs_d     = cs_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    cancel_d = 1'b0;
    err_d    = 1'b0;
    end_pkt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = HEAD;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          plen_d  = pick_len;
          cs_d    = pick_cs;
          rem_d   = pick_len;
        end
      end
      HEAD: begin
        if (g_cancel) begin
          cancel_d = 1'b1;
          end_pkt  = 1'b1;
        end else if (app_ready_v_i) begin
          state_d = DATA;
          tmo_d   = '0;
        end
      end
      DATA: begin
        // Priority: cancel, empty packet, accepted beat (overrun before subtract), timeout.
        if (g_cancel) begin
          cancel_d = 1'b1;
          end_pkt  = 1'b1;
        end else if (rem_q == '0) begin
          end_pkt = 1'b1;
        end else if (beat_acc) begin
          tmo_d = '0;
          if (blen > rem_q) begin
            cancel_d = 1'b1;
            err_d    = 1'b1;
            end_pkt  = 1'b1;
          end else begin
            rem_d = rem_q - blen;
            if (blen == rem_q) end_pkt = 1'b1;
          end
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          cancel_d = 1'b1;
          err_d    = 1'b1;
          end_pkt  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (end_pkt) begin
      state_d = GAP;
      gnt_d   = '0;
      gap_d   = '0;
      ptr_d   = (idx_q == PTR_W'(REQ_N - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      plen_q   <= '0;
      cs_q     <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      cancel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      plen_q   <= plen_d;
      cs_q     <= cs_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      cancel_q <= cancel_d;
      err_q    <= err_d;
    end
  end

  assign req_gnt_o     = gnt_q;
  assign req_ready_o   = data_ok ? gnt_q : '0;
  assign app_early_v_o = (state_q == HEAD) || (state_q == DATA);
  assign app_pkt_len_o = plen_q;
  assign app_cs_o      = cs_q;
  assign app_cancel_o  = cancel_q;
  assign app_valid_o   = beat_acc;
  assign app_data_o    = g_data;
  assign app_len_o     = g_len;
  assign err_o         = err_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: cycle table for single-requester packets plus corner-case sequences.
module tb_eth_tx_arb;

  logic        clk;
  logic        nreset;
  logic [1:0]  early, cancel, valid;
  logic [15:0] plen0, plen1, cs0, cs1, data0, data1;
  logic [1:0]  len0, len1;
  logic        app_ready;

  logic [1:0]  req_gnt, req_ready;
  logic        app_early_v, app_cancel, app_valid, err;
  logic [15:0] app_pkt_len, app_cs, app_data;
  logic [1:0]  app_len;

  int checks = 0;
  int errors = 0;

  eth_tx_arb #(
    .REQ_N     (2),
    .DATA_W    (16),
    .PKT_LEN_W (16),
    .UDP_CS_W  (16),
    .GAP_CYC   (3),
    .TMO_CYC   (64)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .req_early_v_i (early),
    .req_pkt_len_i ({plen1, plen0}),
    .req_cs_i      ({cs1, cs0}),
    .req_cancel_i  (cancel),
    .req_valid_i   (valid),
    .req_data_i    ({data1, data0}),
    .req_len_i     ({len1, len0}),
    .req_gnt_o     (req_gnt),
    .req_ready_o   (req_ready),
    .app_early_v_o (app_early_v),
    .app_pkt_len_o (app_pkt_len),
    .app_cs_o      (app_cs),
    .app_cancel_o  (app_cancel),
    .app_valid_o   (app_valid),
    .app_data_o    (app_data),
    .app_len_o     (app_len),
    .app_ready_v_i (app_ready),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  early, valid, cancel;
    logic [15:0] plen0;
    logic [1:0]  len0;
    logic [15:0] data0;
    logic        ready;
    logic [1:0]  e_gnt, e_rdy;
    logic        e_ev, e_av, e_cancel, e_err;
    logic [15:0] e_plen;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] e, input logic [1:0] v, input logic [1:0] c,
                     input logic [15:0] pl, input logic [1:0] l, input logic [15:0] d,
                     input logic r, input logic [1:0] eg, input logic [1:0] er,
                     input logic eev, input logic eav, input logic ec, input logic ee,
                     input logic [15:0] epl);
    vec_t t;
    t.early = e; t.valid = v; t.cancel = c; t.plen0 = pl; t.len0 = l; t.data0 = d;
    t.ready = r; t.e_gnt = eg; t.e_rdy = er; t.e_ev = eev; t.e_av = eav;
    t.e_cancel = ec; t.e_err = ee; t.e_plen = epl;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    early = '0; cancel = '0; valid = '0;
    plen0 = '0; plen1 = '0; cs0 = '0; cs1 = '0;
    data0 = '0; data1 = '0; len0 = '0; len1 = '0;
    app_ready = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(req_gnt),     0);
    chk({tag, "_ready"},  32'(req_ready),   0);
    chk({tag, "_early"},  32'(app_early_v), 0);
    chk({tag, "_plen"},   32'(app_pkt_len), 0);
    chk({tag, "_cs"},     32'(app_cs),      0);
    chk({tag, "_cancel"}, 32'(app_cancel),  0);
    chk({tag, "_valid"},  32'(app_valid),   0);
    chk({tag, "_data"},   32'(app_data),    0);
    chk({tag, "_len"},    32'(app_len),     0);
    chk({tag, "_err"},    32'(err),         0);
  endtask

  initial begin
    int ngr;
    int last_cyc;
    logic [1:0] prev_gnt;
    int rem_req[2];

    nreset = 1'b0;
    clear_inputs();
    #3;
    chk_all_zero("reset");
    do_reset();
    chk_all_zero("post_reset");

    // len=5 as 2,2,1 with one stalled beat; len=3 overrun; pkt_len=0.
    //   early valid cancel plen len data    rdy  gnt  rdy  ev av cn er eplen
    add(2'b01, 2'b00, 2'b00, 5, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 2'b00, 5, 0, 16'h0000, 1, 2'b01, 2'b00, 1, 0, 0, 0, 5);
    add(2'b00, 2'b01, 2'b00, 5, 2, 16'h1111, 1, 2'b01, 2'b01, 1, 1, 0, 0, 5);
    add(2'b00, 2'b01, 2'b00, 5, 2, 16'h2222, 0, 2'b01, 2'b00, 1, 0, 0, 0, 5);
    add(2'b00, 2'b01, 2'b00, 5, 2, 16'h2222, 1, 2'b01, 2'b01, 1, 1, 0, 0, 5);
    add(2'b00, 2'b01, 2'b00, 5, 1, 16'h3333, 1, 2'b01, 2'b01, 1, 1, 0, 0, 5);
    add(2'b00, 2'b00, 2'b00, 5, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 5);
    add(2'b00, 2'b00, 2'b00, 5, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 5);
    add(2'b00, 2'b00, 2'b00, 5, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 5);
    add(2'b01, 2'b00, 2'b00, 3, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 5);
    add(2'b00, 2'b00, 2'b00, 3, 0, 16'h0000, 1, 2'b01, 2'b00, 1, 0, 0, 0, 3);
    add(2'b00, 2'b01, 2'b00, 3, 2, 16'h4444, 1, 2'b01, 2'b01, 1, 1, 0, 0, 3);
    add(2'b00, 2'b01, 2'b00, 3, 2, 16'h5555, 1, 2'b01, 2'b01, 1, 1, 0, 0, 3);
    add(2'b00, 2'b00, 2'b00, 3, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 1, 1, 3);
    add(2'b00, 2'b00, 2'b00, 3, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 3);
    add(2'b00, 2'b00, 2'b00, 3, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 3);
    add(2'b01, 2'b00, 2'b00, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 3);
    add(2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 1, 2'b01, 2'b00, 1, 0, 0, 0, 0);
    add(2'b00, 2'b01, 2'b00, 0, 2, 16'h6666, 1, 2'b01, 2'b00, 1, 0, 0, 0, 0);
    add(2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      early = tbl[k].early; valid = tbl[k].valid; cancel = tbl[k].cancel;
      plen0 = tbl[k].plen0; len0 = tbl[k].len0; data0 = tbl[k].data0;
      app_ready = tbl[k].ready;
      #1;
      chk($sformatf("v%0d_gnt", k),    32'(req_gnt),     32'(tbl[k].e_gnt));
      chk($sformatf("v%0d_ready", k),  32'(req_ready),   32'(tbl[k].e_rdy));
      chk($sformatf("v%0d_early", k),  32'(app_early_v), 32'(tbl[k].e_ev));
      chk($sformatf("v%0d_valid", k),  32'(app_valid),   32'(tbl[k].e_av));
      chk($sformatf("v%0d_cancel", k), 32'(app_cancel),  32'(tbl[k].e_cancel));
      chk($sformatf("v%0d_err", k),    32'(err),         32'(tbl[k].e_err));
      chk($sformatf("v%0d_plen", k),   32'(app_pkt_len), 32'(tbl[k].e_plen));
      if (tbl[k].e_av) begin
        chk($sformatf("v%0d_data", k), 32'(app_data), 32'(tbl[k].data0));
        chk($sformatf("v%0d_len", k),  32'(app_len),  32'(tbl[k].len0));
      end
      tick();
    end

    // Round robin: both request two 4-byte packets each, expect grants 0,1,0,1.
    do_reset();
    plen0 = 4; plen1 = 4; len0 = 2; len1 = 2; valid = 2'b11; app_ready = 1'b1;
    rem_req[0] = 2; rem_req[1] = 2;
    ngr = 0; last_cyc = 0; prev_gnt = '0;
    for (int cyc = 0; cyc < 300 && ngr < 4; cyc++) begin
      if (req_gnt != 2'b00 && prev_gnt == 2'b00) begin
        chk($sformatf("rr_grant%0d", ngr), 32'(req_gnt), (ngr % 2 == 0) ? 32'd1 : 32'd2);
        if (ngr > 0) chk($sformatf("rr_spacing%0d", ngr), 32'((cyc - last_cyc) >= 4), 1);
        if (req_gnt[0]) rem_req[0]--;
        if (req_gnt[1]) rem_req[1]--;
        last_cyc = cyc;
        ngr++;
      end
      chk("rr_onehot", 32'($onehot0(req_gnt)), 1);
      chk("rr_no_cancel", 32'(app_cancel | err), 0);
      prev_gnt = req_gnt;
      early = {rem_req[1] > 0, rem_req[0] > 0};
      tick();
    end
    chk("rr_grant_count", 32'(ngr), 4);

    // Requester 1 cancels with a valid beat; next grant goes to requester 0 despite both requesting.
    do_reset();
    plen1 = 6; cs1 = 16'h1234; len0 = 2; len1 = 2; data1 = 16'hC0DE;
    app_ready = 1'b1; early = 2'b10;
    #1; chk("cx_idle_gnt", 32'(req_gnt), 0);
    tick();
    early = 2'b01; #1;
    chk("cx_head_gnt", 32'(req_gnt), 2);
    chk("cx_head_cs", 32'(app_cs), 32'h1234);
    chk("cx_head_plen", 32'(app_pkt_len), 6);
    tick();
    valid = 2'b11; #1;
    chk("cx_d1_ready", 32'(req_ready), 2);
    chk("cx_d1_valid", 32'(app_valid), 1);
    chk("cx_d1_data", 32'(app_data), 32'hC0DE);
    tick();
    cancel = 2'b10; #1;
    chk("cx_drop_ready", 32'(req_ready), 0);
    chk("cx_drop_valid", 32'(app_valid), 0);
    chk("cx_drop_cancel", 32'(app_cancel), 0);
    tick();
    cancel = 2'b00; valid = 2'b00; early = 2'b11; #1;
    chk("cx_pulse_cancel", 32'(app_cancel), 1);
    chk("cx_pulse_err", 32'(err), 0);
    chk("cx_gap_gnt", 32'(req_gnt), 0);
    chk("cx_gap_early", 32'(app_early_v), 0);
    tick();
    chk("cx_pulse_end", 32'(app_cancel), 0);
    tick(); tick();
    chk("cx_idle2_gnt", 32'(req_gnt), 0);
    tick();
    chk("cx_next_gnt", 32'(req_gnt), 1);

    // Timeout: beat on the 63rd DATA cycle restarts the count; then 64 stalls force cancel.
    do_reset();
    plen0 = 10; len0 = 2; app_ready = 1'b1; early = 2'b01;
    tick();
    early = 2'b00; #1;
    chk("tmo_head_gnt", 32'(req_gnt), 1);
    tick();
    for (int i = 1; i <= 62; i++) begin
      #1;
      chk($sformatf("tmo_a%0d_cancel", i), 32'(app_cancel), 0);
      chk($sformatf("tmo_a%0d_early", i), 32'(app_early_v), 1);
      tick();
    end
    valid = 2'b01; #1;
    chk("tmo_restart_valid", 32'(app_valid), 1);
    tick();
    valid = 2'b00;
    for (int j = 1; j <= 64; j++) begin
      #1;
      chk($sformatf("tmo_b%0d_cancel", j), 32'(app_cancel), 0);
      chk($sformatf("tmo_b%0d_err", j), 32'(err), 0);
      chk($sformatf("tmo_b%0d_early", j), 32'(app_early_v), 1);
      tick();
    end
    chk("tmo_cancel", 32'(app_cancel), 1);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_gnt", 32'(req_gnt), 0);
    tick();
    chk("tmo_cancel_end", 32'(app_cancel), 0);
    chk("tmo_err_end", 32'(err), 0);

    // Asynchronous reset in the middle of DATA clears every output without a clock edge.
    do_reset();
    plen0 = 10; len0 = 2; data0 = 16'hABCD; cs0 = 16'h5A5A; app_ready = 1'b1; early = 2'b01;
    tick();
    early = 2'b00;
    tick();
    valid = 2'b01; #1;
    chk("ar_pre_valid", 32'(app_valid), 1);
    chk("ar_pre_cs", 32'(app_cs), 32'h5A5A);
    #2;
    nreset = 1'b0;
    #1;
    chk_all_zero("ar");
    @(negedge clk);
    nreset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
